// File: rtl/stopwatch_ctrl.sv
// Stopwatch control: button debouncing plus run/lap/stop sequencing of the counter.
// Build option AUTO_STOP_EN: stop at counter terminal value and raise the sticky overflow flag.
module stopwatch_ctrl #(
  parameter int DEBOUNCE_CYCLES = 1000000
) (
  input  logic       clk100MHz,
  input  logic       rst,
  input  logic       tick,
  input  logic       start,
  input  logic       stop,
  input  logic       midstop,
  input  logic       clear,
  input  logic       cnt_max,
  output logic       cnt_en,
  output logic       cnt_clr,
  output logic       disp_freeze,
  output logic       lap_pulse,
  output logic [1:0] state,
  output logic       overflow
);
  // state | meaning
  // IDLE  | cleared, not counting
  // RUN   | counting, display live
  // LAP   | counting, display frozen on the lap capture
  // STOP  | halted, display shows final time
  typedef enum logic [1:0] {IDLE = 2'b00, RUN = 2'b01, LAP = 2'b10, STOP = 2'b11} state_t;

  localparam int CW = (DEBOUNCE_CYCLES > 2) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CW-1:0] DB_LAST = CW'(DEBOUNCE_CYCLES - 1);

  // Button bit order: 0 start, 1 stop, 2 midstop, 3 clear
  logic [3:0]         btn_raw;
  logic [3:0]         sync_a;
  logic [3:0]         sync_b;
  logic [3:0]         stable;
  logic [3:0]         stable_d;
  logic [3:0]         press;
  logic [3:0][CW-1:0] db_cnt;

  assign btn_raw = {clear, midstop, stop, start};

  always_ff @(posedge clk100MHz or posedge rst) begin
    if (rst) begin
      sync_a   <= '0;
      sync_b   <= '0;
      stable   <= '0;
      stable_d <= '0;
      db_cnt   <= '0;
    end else begin
      sync_a   <= btn_raw;
      sync_b   <= sync_a;
      stable_d <= stable;
      for (int i = 0; i < 4; i++) begin
        if (sync_b[i] == stable[i]) begin
          db_cnt[i] <= '0;
        end else if (db_cnt[i] == DB_LAST) begin
          stable[i] <= sync_b[i];
          db_cnt[i] <= '0;
        end else begin
          db_cnt[i] <= db_cnt[i] + CW'(1);
        end
      end
    end
  end

  assign press = stable & ~stable_d;

  state_t st_q;
  state_t st_d;
  logic   lap_d;
  logic   clr_d;
  logic   freeze_d;
  logic   ovf_d;
  logic   auto_hit;

`ifdef AUTO_STOP_EN
  assign auto_hit = cnt_max & ((st_q == RUN) | (st_q == LAP));
`else
  logic unused_cnt_max;
  assign unused_cnt_max = cnt_max;
  assign auto_hit       = 1'b0;
`endif

  always_comb begin
    st_d     = st_q;
    lap_d    = 1'b0;
    clr_d    = 1'b0;
    freeze_d = disp_freeze;
    ovf_d    = overflow;
    if (press[3]) begin
      st_d     = IDLE;
      clr_d    = 1'b1;
      freeze_d = 1'b0;
      ovf_d    = 1'b0;
    end else if (auto_hit) begin
      // Leaving LAP still captures, so the display shows the terminal value
      st_d     = STOP;
      lap_d    = (st_q == LAP);
      freeze_d = 1'b0;
      ovf_d    = 1'b1;
    end else begin
      case (st_q)
        IDLE: if (press[0]) st_d = RUN;
        RUN: begin
          if (press[1]) begin
            st_d = STOP;
          end else if (press[2]) begin
            st_d     = LAP;
            lap_d    = 1'b1;
            freeze_d = 1'b1;
          end
        end
        LAP: begin
          if (press[1]) begin
            st_d     = STOP;
            lap_d    = 1'b1;
            freeze_d = 1'b0;
          end else if (press[2]) begin
            st_d     = RUN;
            freeze_d = 1'b0;
          end
        end
        STOP: if (press[0]) st_d = RUN;
        default: st_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk100MHz or posedge rst) begin
    if (rst) begin
      st_q        <= IDLE;
      lap_pulse   <= 1'b0;
      cnt_clr     <= 1'b0;
      disp_freeze <= 1'b0;
      overflow    <= 1'b0;
    end else begin
      st_q        <= st_d;
      lap_pulse   <= lap_d;
      cnt_clr     <= clr_d;
      disp_freeze <= freeze_d;
      overflow    <= ovf_d;
    end
  end

  assign state  = st_q;
  assign cnt_en = tick & ((st_q == RUN) | (st_q == LAP)) & ~auto_hit;

endmodule

// File: tb/tb_stopwatch_ctrl.sv
// Bench for stopwatch_ctrl: directed scenarios plus random button traffic, every cycle
// compared against a sample-window debounce model and an event-priority FSM model.
module tb_stopwatch_ctrl;
  localparam int DB = 4;
`ifdef AUTO_STOP_EN
  localparam bit AUTO = 1'b1;
`else
  localparam bit AUTO = 1'b0;
`endif

  logic       clk100MHz = 1'b0;
  logic       rst = 1'b1;
  logic       tick = 1'b0;
  logic       start = 1'b0;
  logic       stop = 1'b0;
  logic       midstop = 1'b0;
  logic       clear = 1'b0;
  logic       cnt_max = 1'b0;
  logic       cnt_en;
  logic       cnt_clr;
  logic       disp_freeze;
  logic       lap_pulse;
  logic [1:0] state;
  logic       overflow;

  int n_checks = 0;
  int n_fail = 0;
  bit mon_en = 1'b0;
  bit cm_rand = 1'b0;
  int tcnt = 0;

  stopwatch_ctrl #(.DEBOUNCE_CYCLES(DB)) dut (
    .clk100MHz  (clk100MHz),
    .rst        (rst),
    .tick       (tick),
    .start      (start),
    .stop       (stop),
    .midstop    (midstop),
    .clear      (clear),
    .cnt_max    (cnt_max),
    .cnt_en     (cnt_en),
    .cnt_clr    (cnt_clr),
    .disp_freeze(disp_freeze),
    .lap_pulse  (lap_pulse),
    .state      (state),
    .overflow   (overflow)
  );

  always #5 clk100MHz = ~clk100MHz;

  initial begin
    forever begin
      @(posedge clk100MHz);
      #1;
      tcnt = (tcnt + 1) % 10;
      tick = (tcnt == 0);
    end
  end

  task automatic chk_val(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Reference model. Button order: 0 start, 1 stop, 2 midstop, 3 clear.
  bit m_samp   [4][DB+2];
  bit m_stable [4];
  bit m_pend   [4];
  int m_st;
  bit m_lp, m_cc, m_fz, m_ov;

  function automatic void model_reset();
    for (int b = 0; b < 4; b++) begin
      for (int j = 0; j < DB + 2; j++) m_samp[b][j] = 1'b0;
      m_stable[b] = 1'b0;
      m_pend[b]   = 1'b0;
    end
    m_st = 0;
    m_lp = 1'b0;
    m_cc = 1'b0;
    m_fz = 1'b0;
    m_ov = 1'b0;
  endfunction

  // A level is accepted once the DB samples that have cleared the synchronizer all disagree with it.
  function automatic void model_buttons(input logic [3:0] r);
    bit all_diff;
    for (int b = 0; b < 4; b++) begin
      for (int j = DB + 1; j > 0; j--) m_samp[b][j] = m_samp[b][j-1];
      m_samp[b][0] = r[b];
      all_diff = 1'b1;
      for (int j = 2; j <= DB + 1; j++) if (m_samp[b][j] == m_stable[b]) all_diff = 1'b0;
      m_pend[b] = 1'b0;
      if (all_diff) begin
        m_stable[b] = !m_stable[b];
        m_pend[b]   = m_stable[b];
      end
    end
  endfunction

  function automatic void model_fsm(input bit ev_start, input bit ev_stop, input bit ev_mid,
                                    input bit ev_clr, input bit at_max);
    bit running;
    running = (m_st == 1) || (m_st == 2);
    m_lp = 1'b0;
    m_cc = 1'b0;
    if (ev_clr) begin
      m_st = 0; m_cc = 1'b1; m_fz = 1'b0; m_ov = 1'b0;
    end else if (AUTO && running && at_max) begin
      m_lp = (m_st == 2); m_st = 3; m_fz = 1'b0; m_ov = 1'b1;
    end else if (ev_stop && running) begin
      m_lp = (m_st == 2); m_st = 3; m_fz = 1'b0;
    end else if (ev_mid && running) begin
      if (m_st == 1) begin
        m_st = 2; m_lp = 1'b1; m_fz = 1'b1;
      end else begin
        m_st = 1; m_fz = 1'b0;
      end
    end else if (ev_start && !running) begin
      m_st = 1;
    end
  endfunction

  always @(posedge clk100MHz or posedge rst) begin
    if (rst) begin
      model_reset();
    end else begin
      model_fsm(m_pend[0], m_pend[1], m_pend[2], m_pend[3], cnt_max);
      model_buttons({clear, midstop, stop, start});
    end
  end

  always @(negedge clk100MHz) begin
    if (mon_en) begin
      chk_val("state", 8'(state), 8'(m_st));
      chk_val("cnt_clr", 8'(cnt_clr), 8'(m_cc));
      chk_val("lap_pulse", 8'(lap_pulse), 8'(m_lp));
      chk_val("disp_freeze", 8'(disp_freeze), 8'(m_fz));
      chk_val("overflow", 8'(overflow), 8'(m_ov));
      chk_val("cnt_en", 8'(cnt_en), 8'(tick && (m_st == 1 || m_st == 2) && !(AUTO && cnt_max)));
    end
  end

  task automatic set_btn(input logic [3:0] m);
    start   = m[0];
    stop    = m[1];
    midstop = m[2];
    clear   = m[3];
  endtask

  task automatic cycles(input int n);
    repeat (n) begin
      @(posedge clk100MHz);
      #1;
      if (cm_rand) cnt_max = ($urandom_range(0, 19) == 0);
    end
  endtask

  task automatic press(input logic [3:0] m, input int len);
    set_btn(m);
    cycles(len);
    set_btn(4'b0000);
    cycles(DB + 6);
  endtask

  task automatic async_reset_check();
    @(posedge clk100MHz);
    #3;
    rst = 1'b1;
    #1;
    chk_val("arst_state", 8'(state), 8'd0);
    chk_val("arst_freeze", 8'(disp_freeze), 8'd0);
    chk_val("arst_lap", 8'(lap_pulse), 8'd0);
    chk_val("arst_clr", 8'(cnt_clr), 8'd0);
    chk_val("arst_ovf", 8'(overflow), 8'd0);
    chk_val("arst_en", 8'(cnt_en), 8'd0);
    cycles(2);
    rst = 1'b0;
    cycles(1);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1);
  end

  initial begin
    int k;
    logic [3:0] m;
    int len;
    cycles(3);
    chk_val("rst_state", 8'(state), 8'd0);
    chk_val("rst_clr", 8'(cnt_clr), 8'd0);
    chk_val("rst_lap", 8'(lap_pulse), 8'd0);
    chk_val("rst_freeze", 8'(disp_freeze), 8'd0);
    chk_val("rst_ovf", 8'(overflow), 8'd0);
    rst = 1'b0;
    mon_en = 1'b1;
    cycles(2);

    // Start held 12 cycles: RUN appears exactly at edge DB+3
    set_btn(4'b0001);
    repeat (6) @(posedge clk100MHz);
    @(negedge clk100MHz);
    chk_val("lat_edge6", 8'(state), 8'd0);
    @(negedge clk100MHz);
    chk_val("lat_edge7", 8'(state), 8'd1);
    repeat (5) @(posedge clk100MHz);
    #1;
    set_btn(4'b0000);
    cycles(30);
    chk_val("one_event", 8'(state), 8'd1);

    press(4'b0010, 2);
    chk_val("stop_glitch", 8'(state), 8'd1);
    press(4'b0010, 10);
    chk_val("stop_press", 8'(state), 8'd3);
    cycles(12);
    press(4'b0001, $urandom_range(DB, 8));
    chk_val("resume", 8'(state), 8'd1);

    press(4'b0100, $urandom_range(DB, 8));
    chk_val("lap_state", 8'(state), 8'd2);
    chk_val("lap_freeze", 8'(disp_freeze), 8'd1);
    cycles(12);
    press(4'b0100, $urandom_range(DB, 8));
    chk_val("unlap_state", 8'(state), 8'd1);
    chk_val("unlap_freeze", 8'(disp_freeze), 8'd0);

    press(4'b0100, DB);
    press(4'b0110, 6);
    chk_val("lap_stop_state", 8'(state), 8'd3);
    chk_val("lap_stop_freeze", 8'(disp_freeze), 8'd0);

    press(4'b1000, 5);
    chk_val("clear_state", 8'(state), 8'd0);
    press(4'b0001, 5);
    press(4'b1001, 5);
    chk_val("clear_wins", 8'(state), 8'd0);

    // Start held through a reset still yields one event after release
    set_btn(4'b0001);
    cycles(3);
    rst = 1'b1;
    cycles(2);
    rst = 1'b0;
    cycles(DB + 5);
    chk_val("held_thru_rst", 8'(state), 8'd1);
    set_btn(4'b0000);
    cycles(DB + 6);

`ifdef AUTO_STOP_EN
    k = 0;
    @(posedge clk100MHz);
    #2;
    while (!tick && k < 30) begin
      @(posedge clk100MHz);
      #2;
      k++;
    end
    chk_val("tick_wait", 8'(tick), 8'd1);
    cnt_max = 1'b1;
    #1;
    chk_val("auto_en_off", 8'(cnt_en), 8'd0);
    @(posedge clk100MHz);
    #1;
    cnt_max = 1'b0;
    @(negedge clk100MHz);
    chk_val("auto_state", 8'(state), 8'd3);
    chk_val("auto_ovf", 8'(overflow), 8'd1);
    cycles(1);
    press(4'b1000, 5);
    chk_val("ovf_cleared", 8'(overflow), 8'd0);
    press(4'b0001, 5);
    press(4'b0100, 5);
    cnt_max = 1'b1;
    cycles(1);
    cnt_max = 1'b0;
    cycles(2);
    chk_val("auto_from_lap", 8'(state), 8'd3);
`else
    cnt_max = 1'b1;
    cycles(3);
    cnt_max = 1'b0;
    chk_val("no_auto_state", 8'(state), 8'd1);
    chk_val("no_auto_ovf", 8'(overflow), 8'd0);
`endif

    press(4'b0001, 5);
    chk_val("run_again", 8'(state), 8'd1);
    press(4'b0100, 5);
    async_reset_check();

    cm_rand = 1'b1;
    for (int it = 0; it < 250; it++) begin
      if ($urandom_range(0, 3) != 0) m = 4'(1 << $urandom_range(0, 3));
      else m = 4'($urandom_range(1, 15));
      if (m[3] && $urandom_range(0, 1) == 0 && m != 4'b1000) m[3] = 1'b0;
      len = $urandom_range(1, 9);
      if ($urandom_range(0, 24) == 0) async_reset_check();
      press(m, len);
      cycles($urandom_range(1, 5));
    end
    cm_rand = 1'b0;
    cnt_max = 1'b0;
    set_btn(4'b0000);
    cycles(10);
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
